// File: rtl/fft_frame_sched_if.sv
// Stream bundle for fft_frame_sched: free-running ADC input (*_s)
// and framed output towards the window stage (*_m).
// Ports: tdata_s/tvalid_s/tready_s input stream,
//        tdata_m/tvalid_m/tuser_m/tlast_m/tready_m output stream.
// slave = scheduler view, master = environment (source + sink) view.
interface fft_frame_sched_if #(
    parameter int DW = 16
);
    logic [DW-1:0] tdata_s;
    logic          tvalid_s;
    logic          tready_s;
    logic [DW-1:0] tdata_m;
    logic          tvalid_m;
    logic          tuser_m;
    logic          tlast_m;
    logic          tready_m;

    modport slave (
        input  tdata_s, tvalid_s, tready_m,
        output tready_s, tdata_m, tvalid_m, tuser_m, tlast_m
    );

    modport master (
        output tdata_s, tvalid_s, tready_m,
        input  tready_s, tdata_m, tvalid_m, tuser_m, tlast_m
    );
endinterface

// File: rtl/fft_frame_sched.sv
// FFT frame scheduler: cuts a free-running sample stream into frames
// of FRAME_LEN samples with optional inter-frame skip and run control.
// Ports: clk, reset_n (async, active-low); bus (stream bundle, slave);
//        cfg_start/cfg_abort pulses, cfg_continuous, cfg_nframes,
//        cfg_skip; busy, done, frame_cnt status.
// Macro FFT_FRAME_SCHED_TRIG_EN adds trig_in and the WAIT_TRIG state.
module fft_frame_sched #(
    parameter int DW        = 16,
    parameter int FRAME_LEN = 1024,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    fft_frame_sched_if.slave bus,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic             cfg_continuous,
    input  logic [CNT_W-1:0] cfg_nframes,
    input  logic [CNT_W-1:0] cfg_skip,
`ifdef FFT_FRAME_SCHED_TRIG_EN
    input  logic             trig_in,
`endif
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int IW = $clog2(FRAME_LEN);
    localparam logic [IW-1:0] LAST = IW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_SKIP    = 2'd2
`ifdef FFT_FRAME_SCHED_TRIG_EN
        ,
        S_WAIT_TRIG = 2'd3
`endif
    } state_t;

`ifdef FFT_FRAME_SCHED_TRIG_EN
    localparam state_t START_ST = S_WAIT_TRIG;
`else
    localparam state_t START_ST = S_CAPTURE;
`endif

    state_t           r_state;
    logic [IW-1:0]    r_idx;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] r_skip_cnt;
    logic [CNT_W-1:0] r_nframes;
    logic [CNT_W-1:0] r_skip;
    logic             r_cont;
    logic             r_abort_pend;
    logic             r_busy;
    logic             r_done;

    logic [DW-1:0]    w_data;
    logic             w_cap;
    logic             w_hs;
    logic             w_last;
    logic             w_stop;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_skip_inc;

    assign w_data     = bus.tdata_s;
    assign w_cap      = (r_state == S_CAPTURE);
    assign w_hs       = w_cap & bus.tvalid_s & bus.tready_m;
    assign w_last     = (r_idx == LAST);
    assign w_cnt_inc  = r_frame_cnt + 1'b1;
    assign w_skip_inc = r_skip_cnt + 1'b1;
    // A same-cycle abort at the tlast handshake ends the run too.
    assign w_stop     = r_abort_pend | cfg_abort
                      | (~r_cont & (w_cnt_inc == r_nframes));

    assign bus.tdata_m  = w_data;
    assign bus.tvalid_m = bus.tvalid_s & w_cap;
    assign bus.tuser_m  = w_cap & (r_idx == '0);
    assign bus.tlast_m  = w_cap & w_last;
    assign bus.tready_s = w_cap ? bus.tready_m : 1'b1;

    assign busy      = r_busy;
    assign done      = r_done;
    assign frame_cnt = r_frame_cnt;

`ifdef FFT_FRAME_SCHED_TRIG_EN
    logic r_trig_s1;
    logic r_trig_s2;
    logic r_trig_d;
    logic w_trig_rise;

    assign w_trig_rise = r_trig_s2 & ~r_trig_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_trig_s1 <= 1'b0;
            r_trig_s2 <= 1'b0;
            r_trig_d  <= 1'b0;
        end else begin
            r_trig_s1 <= trig_in;
            r_trig_s2 <= r_trig_s1;
            r_trig_d  <= r_trig_s2;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_frame_cnt  <= '0;
            r_skip_cnt   <= '0;
            r_nframes    <= '0;
            r_skip       <= '0;
            r_cont       <= 1'b0;
            r_abort_pend <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (cfg_start && !cfg_abort) begin
                        r_cont       <= cfg_continuous;
                        r_nframes    <= (cfg_nframes == '0)
                                      ? CNT_W'(1) : cfg_nframes;
                        r_skip       <= cfg_skip;
                        r_frame_cnt  <= '0;
                        r_idx        <= '0;
                        r_skip_cnt   <= '0;
                        r_abort_pend <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= START_ST;
                    end
                end
                S_CAPTURE: begin
                    // Abort waits for tlast so frames are never cut short.
                    if (cfg_abort)
                        r_abort_pend <= 1'b1;
                    if (w_hs) begin
                        if (w_last) begin
                            r_idx       <= '0;
                            r_frame_cnt <= w_cnt_inc;
                            if (w_stop) begin
                                r_state      <= S_IDLE;
                                r_busy       <= 1'b0;
                                r_done       <= 1'b1;
                                r_abort_pend <= 1'b0;
                            end else if (r_skip != '0) begin
                                r_state    <= S_SKIP;
                                r_skip_cnt <= '0;
                            end
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_SKIP: begin
                    if (cfg_abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (bus.tvalid_s) begin
                        if (w_skip_inc == r_skip) begin
                            r_state    <= S_CAPTURE;
                            r_skip_cnt <= '0;
                        end else begin
                            r_skip_cnt <= w_skip_inc;
                        end
                    end
                end
`ifdef FFT_FRAME_SCHED_TRIG_EN
                S_WAIT_TRIG: begin
                    if (cfg_abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_trig_rise) begin
                        r_state <= S_CAPTURE;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_sched.sv
// Self-checking bench for fft_frame_sched with FRAME_LEN=8.
// Expected beats are queued at run start and popped per output beat.
module tb_fft_frame_sched;
    localparam int DW = 16;
    localparam int FL = 8;
    localparam int CW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          user;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_abort = 1'b0;
    logic          cfg_continuous = 1'b0;
    logic [CW-1:0] cfg_nframes = '0;
    logic [CW-1:0] cfg_skip = '0;
    logic          busy;
    logic          done;
    logic [CW-1:0] frame_cnt;
    logic [DW-1:0] src_val = '0;
`ifdef FFT_FRAME_SCHED_TRIG_EN
    logic          trig_in = 1'b0;
`endif

    fft_frame_sched_if #(.DW(DW)) bus ();

    always #5 clk = ~clk;

    assign bus.tdata_s = src_val;

    fft_frame_sched #(
        .DW(DW),
        .FRAME_LEN(FL),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave),
        .cfg_start(cfg_start),
        .cfg_abort(cfg_abort),
        .cfg_continuous(cfg_continuous),
        .cfg_nframes(cfg_nframes),
        .cfg_skip(cfg_skip),
`ifdef FFT_FRAME_SCHED_TRIG_EN
        .trig_in(trig_in),
`endif
        .busy(busy),
        .done(done),
        .frame_cnt(frame_cnt)
    );

    int nchk = 0;
    int nerr = 0;
    beat_t q[$];
    beat_t e;
    int nb, ndone, last_cyc, done_cyc, nskip, nstall;

    logic          s_ihs, s_ohs, s_valid, s_user, s_last;
    logic          s_rdy_s, s_busy, s_done;
    logic [DW-1:0] s_data;
    logic [CW-1:0] s_cnt;

    // Sample one cycle at negedge, then step to just after posedge.
    task automatic tick();
        @(negedge clk);
        s_ihs   = bus.tvalid_s && bus.tready_s;
        s_ohs   = bus.tvalid_m && bus.tready_m;
        s_valid = bus.tvalid_m;
        s_data  = bus.tdata_m;
        s_user  = bus.tuser_m;
        s_last  = bus.tlast_m;
        s_rdy_s = bus.tready_s;
        s_busy  = busy;
        s_done  = done;
        s_cnt   = frame_cnt;
        @(posedge clk);
        #1;
        if (s_ihs) src_val = src_val + 1'b1;
    endtask

    task automatic push_frame(input int base);
        for (int i = 0; i < FL; i++)
            q.push_back('{data: DW'(base + i),
                          user: (i == 0),
                          last: (i == FL - 1)});
    endtask

    // Source restarts at 0 on the first sample the run can capture.
    task automatic start_run(input logic cont,
                             input logic [CW-1:0] nf,
                             input logic [CW-1:0] sk);
        cfg_continuous = cont;
        cfg_nframes = nf;
        cfg_skip = sk;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        src_val = '0;
        nb = 0; ndone = 0; last_cyc = -1; done_cyc = -1;
        nskip = 0; nstall = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.tvalid_s = 1'b1;
        bus.tready_m = 1'b1;
        tick();
        tick();
        nchk++;
        if ({s_busy, s_done, s_valid, s_user, s_last} !== 5'b0) begin
            nerr++;
            $display("FAIL reset_outs got %b exp 00000",
                     {s_busy, s_done, s_valid, s_user, s_last});
        end
        nchk++;
        if (s_cnt !== '0) begin
            nerr++;
            $display("FAIL reset_cnt got %0d exp 0", s_cnt);
        end
        nchk++;
        if (s_rdy_s !== 1'b1) begin
            nerr++;
            $display("FAIL reset_tready_s got %b exp 1", s_rdy_s);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_start_abort();
        cfg_start = 1'b1;
        cfg_abort = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        tick();
        nchk++;
        if ({s_busy, s_done, s_valid} !== 3'b0) begin
            nerr++;
            $display("FAIL start_abort got %b exp 000",
                     {s_busy, s_done, s_valid});
        end
    endtask

    task automatic test_two_frames();
        start_run(1'b0, 16'd2, 16'd0);
        push_frame(0);
        push_frame(8);
        for (int c = 0; c < 40; c++) begin
            // A second start mid-run must be ignored.
            cfg_start = (nb == 4);
            cfg_nframes = (nb == 4) ? 16'd5 : 16'd2;
            tick();
            if (s_ohs) begin
                nchk++;
                if (q.size() == 0) begin
                    nerr++;
                    $display("FAIL two_frames extra got %0d exp none", s_data);
                end else begin
                    e = q.pop_front();
                    if ({s_data, s_user, s_last} !== e) begin
                        nerr++;
                        $display("FAIL two_frames beat%0d got %0d/%b/%b exp %0d/%b/%b",
                                 nb, s_data, s_user, s_last, e.data, e.user, e.last);
                    end
                end
                nb++;
                last_cyc = c;
            end
            if (s_done) begin
                ndone++;
                done_cyc = c;
            end
        end
        cfg_start = 1'b0;
        nchk++;
        if (nb != 16 || q.size() != 0) begin
            nerr++;
            $display("FAIL two_frames count got %0d exp 16", nb);
        end
        nchk++;
        if (ndone != 1 || done_cyc != last_cyc + 1) begin
            nerr++;
            $display("FAIL two_frames done got n=%0d at %0d exp n=1 at %0d",
                     ndone, done_cyc, last_cyc + 1);
        end
        nchk++;
        if (s_cnt !== 16'd2 || s_busy !== 1'b0) begin
            nerr++;
            $display("FAIL two_frames cnt got %0d busy %b exp 2 busy 0",
                     s_cnt, s_busy);
        end
    endtask

    task automatic test_skip();
        start_run(1'b0, 16'd2, 16'd3);
        push_frame(0);
        push_frame(11);
        for (int c = 0; c < 50; c++) begin
            tick();
            if (s_busy && !s_valid) begin
                nskip++;
                nchk++;
                if (s_rdy_s !== 1'b1) begin
                    nerr++;
                    $display("FAIL skip_tready got %b exp 1", s_rdy_s);
                end
            end
            if (s_ohs) begin
                nchk++;
                if (q.size() == 0) begin
                    nerr++;
                    $display("FAIL skip extra got %0d exp none", s_data);
                end else begin
                    e = q.pop_front();
                    if ({s_data, s_user, s_last} !== e) begin
                        nerr++;
                        $display("FAIL skip beat%0d got %0d/%b/%b exp %0d/%b/%b",
                                 nb, s_data, s_user, s_last, e.data, e.user, e.last);
                    end
                end
                nb++;
            end
            if (s_done) ndone++;
        end
        nchk++;
        if (nskip != 3 || nb != 16 || q.size() != 0) begin
            nerr++;
            $display("FAIL skip counts got skip=%0d beats=%0d exp skip=3 beats=16",
                     nskip, nb);
        end
        nchk++;
        if (ndone != 1 || s_cnt !== 16'd2) begin
            nerr++;
            $display("FAIL skip done got n=%0d cnt=%0d exp n=1 cnt=2",
                     ndone, s_cnt);
        end
    endtask

    task automatic test_abort();
        start_run(1'b1, 16'd0, 16'd0);
        push_frame(0);
        push_frame(8);
        for (int c = 0; c < 60; c++) begin
            // Pulse lands on the cycle presenting idx 3 of frame 2.
            cfg_abort = (nb == 11);
            tick();
            if (s_ohs) begin
                nchk++;
                if (q.size() == 0) begin
                    nerr++;
                    $display("FAIL abort extra got %0d exp none", s_data);
                end else begin
                    e = q.pop_front();
                    if ({s_data, s_user, s_last} !== e) begin
                        nerr++;
                        $display("FAIL abort beat%0d got %0d/%b/%b exp %0d/%b/%b",
                                 nb, s_data, s_user, s_last, e.data, e.user, e.last);
                    end
                end
                nb++;
            end
            if (s_done) ndone++;
        end
        cfg_abort = 1'b0;
        nchk++;
        if (nb != 16 || q.size() != 0) begin
            nerr++;
            $display("FAIL abort count got %0d exp 16", nb);
        end
        nchk++;
        if (ndone != 1 || s_busy !== 1'b0 || s_cnt !== 16'd2) begin
            nerr++;
            $display("FAIL abort end got n=%0d busy=%b cnt=%0d exp 1/0/2",
                     ndone, s_busy, s_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic stall;
        start_run(1'b0, 16'd0, 16'd0);
        push_frame(0);
        for (int c = 0; c < 40; c++) begin
            stall = (nb == 4) && (nstall < 5);
            bus.tready_m = !stall;
            tick();
            if (stall) begin
                nstall++;
                nchk++;
                if ({s_rdy_s, s_valid, s_data} !== {1'b0, 1'b1, 16'd4}) begin
                    nerr++;
                    $display("FAIL stall got rdy=%b v=%b d=%0d exp 0/1/4",
                             s_rdy_s, s_valid, s_data);
                end
            end
            if (s_ohs) begin
                nchk++;
                if (q.size() == 0) begin
                    nerr++;
                    $display("FAIL bp extra got %0d exp none", s_data);
                end else begin
                    e = q.pop_front();
                    if ({s_data, s_user, s_last} !== e) begin
                        nerr++;
                        $display("FAIL bp beat%0d got %0d/%b/%b exp %0d/%b/%b",
                                 nb, s_data, s_user, s_last, e.data, e.user, e.last);
                    end
                end
                nb++;
            end
            if (s_done) ndone++;
        end
        bus.tready_m = 1'b1;
        nchk++;
        if (nstall != 5 || nb != FL || q.size() != 0) begin
            nerr++;
            $display("FAIL bp counts got stall=%0d beats=%0d exp 5/%0d",
                     nstall, nb, FL);
        end
        nchk++;
        if (ndone != 1 || s_cnt !== 16'd1) begin
            nerr++;
            $display("FAIL bp nframes0 got n=%0d cnt=%0d exp 1/1", ndone, s_cnt);
        end
    endtask

    task automatic test_reset_mid();
        start_run(1'b1, 16'd0, 16'd0);
        for (int c = 0; c < 40; c++) begin
            // Cycle 13 presents idx 5 of the second frame.
            if (nb == 13) reset_n = 1'b0;
            tick();
            if (s_ohs) nb++;
            if (!reset_n) break;
        end
        nchk++;
        if (reset_n !== 1'b0 ||
            {s_busy, s_valid, s_user, s_last} !== 4'b0 || s_cnt !== '0) begin
            nerr++;
            $display("FAIL mid_reset got beats=%0d busy=%b v=%b cnt=%0d exp 13/0/0/0",
                     nb, s_busy, s_valid, s_cnt);
        end
        q.delete();
        tick();
        reset_n = 1'b1;
        tick();
        start_run(1'b0, 16'd1, 16'd0);
        push_frame(0);
        for (int c = 0; c < 30; c++) begin
            tick();
            if (s_ohs) begin
                if (nb == 0) begin
                    nchk++;
                    if (s_cnt !== '0) begin
                        nerr++;
                        $display("FAIL restart_cnt got %0d exp 0", s_cnt);
                    end
                end
                nchk++;
                if (q.size() == 0) begin
                    nerr++;
                    $display("FAIL restart extra got %0d exp none", s_data);
                end else begin
                    e = q.pop_front();
                    if ({s_data, s_user, s_last} !== e) begin
                        nerr++;
                        $display("FAIL restart beat%0d got %0d/%b/%b exp %0d/%b/%b",
                                 nb, s_data, s_user, s_last, e.data, e.user, e.last);
                    end
                end
                nb++;
            end
            if (s_done) ndone++;
        end
        nchk++;
        if (nb != FL || q.size() != 0 || ndone != 1 || s_cnt !== 16'd1) begin
            nerr++;
            $display("FAIL restart end got beats=%0d n=%0d cnt=%0d exp %0d/1/1",
                     nb, ndone, s_cnt, FL);
        end
    endtask

`ifdef FFT_FRAME_SCHED_TRIG_EN
    task automatic test_trig();
        int bad;
        int first;
        bad = 0;
        first = -1;
        trig_in = 1'b0;
        start_run(1'b0, 16'd1, 16'd0);
        for (int c = 0; c < 20; c++) begin
            tick();
            if (s_busy !== 1'b1 || s_valid !== 1'b0) bad++;
        end
        nchk++;
        if (bad != 0) begin
            nerr++;
            $display("FAIL trig_wait got %0d bad cycles exp 0", bad);
        end
        trig_in = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (s_user && first < 0) first = c;
        end
        nchk++;
        if (first != 3) begin
            nerr++;
            $display("FAIL trig_latency got %0d exp 3", first);
        end
        trig_in = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        bus.tvalid_s = 1'b0;
        bus.tready_m = 1'b1;
        test_reset();
        test_start_abort();
        test_two_frames();
        test_skip();
        test_abort();
        test_backpressure();
        test_reset_mid();
`ifdef FFT_FRAME_SCHED_TRIG_EN
        test_trig();
`endif
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/fft_frame_sched.md
FFT_FRAME_SCHED -- requirements
Module: fft_frame_sched

Interface
REQ-001 Parameter DW, default 16, sample width in bits.
REQ-002 Parameter FRAME_LEN, default 1024, samples per frame; legal range 2..65536.
REQ-003 Parameter CNT_W, default 16, width of frame-count and skip-count fields.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 tdata_s  in  DW  input sample stream (free-running ADC).
REQ-007 tvalid_s  in  1  input valid.
REQ-008 tready_s  out  1  input ready.
REQ-009 tdata_m  out  DW  framed output to window stage.
REQ-010 tvalid_m  out  1  output valid.
REQ-011 tuser_m  out  1  first sample of frame.
REQ-012 tlast_m  out  1  last sample of frame.
REQ-013 tready_m  in  1  output ready.
REQ-014 cfg_start  in  1  one-cycle start pulse.
REQ-015 cfg_abort  in  1  one-cycle abort pulse.
REQ-016 cfg_continuous  in  1  1 = run until aborted; 0 = run cfg_nframes frames.
REQ-017 cfg_nframes  in  CNT_W  frames per run; 0 treated as 1.
REQ-018 cfg_skip  in  CNT_W  input samples discarded between frames.
REQ-019 trig_in  in  1  external capture trigger; present only with FFT_FRAME_SCHED_TRIG_EN.
REQ-020 busy  out  1  high in any state other than IDLE.
REQ-021 done  out  1  one-cycle pulse on every return to IDLE from an active state.
REQ-022 frame_cnt  out  CNT_W  frames completed in the current run; wraps at 2^CNT_W.

Function
REQ-023 The block SHALL use states IDLE, WAIT_TRIG (macro only), CAPTURE and SKIP.
REQ-024 Datapath: tdata_m = tdata_s, zero latency, combinational.
- tvalid_m = tvalid_s AND state==CAPTURE.
- tready_s = tready_m in CAPTURE, constant 1 otherwise (samples discarded).
REQ-025 Sample index idx SHALL advance only on a CAPTURE handshake (tvalid_s AND tready_m) and wrap to 0 after FRAME_LEN-1.
- tuser_m = (idx==0); tlast_m = (idx==FRAME_LEN-1); both qualified by CAPTURE.
REQ-026 IDLE: cfg_start SHALL latch cfg_continuous, cfg_nframes and cfg_skip, clear frame_cnt and idx, then enter CAPTURE (WAIT_TRIG with macro).
- cfg_start outside IDLE is ignored.
- cfg_start and cfg_abort in the same IDLE cycle: abort wins, state stays IDLE.
REQ-027 On the tlast handshake, frame_cnt SHALL increment, then:
- IDLE with done if abort is pending, or if not continuous and the incremented count equals the latched nframes;
- else SKIP if latched skip != 0;
- else CAPTURE, with back-to-back frames and no idle cycle.
REQ-028 SKIP SHALL count tvalid_s beats and enter CAPTURE on beat number skip; tvalid_s low does not advance the count.
REQ-029 cfg_abort in CAPTURE SHALL be held pending until the current frame's tlast handshake, so no truncated frame is ever emitted; abort in SKIP or WAIT_TRIG returns to IDLE on the next cycle with done.
REQ-030 Backpressure (tready_m low) in CAPTURE SHALL stall idx and hold the frame position; no sample is lost or duplicated.

Reset
REQ-031 While reset_n is low, state SHALL be IDLE and idx, frame_cnt, skip counter, latched config and abort-pending SHALL be 0.
- Outputs busy=0, done=0, tvalid_m=0, tuser_m=0, tlast_m=0.
REQ-032 Reset mid-frame SHALL abandon the frame immediately; the first frame after restart begins at idx 0.

Configuration
REQ-033 Macro FFT_FRAME_SCHED_TRIG_EN, when defined:
- adds trig_in and state WAIT_TRIG;
- trig_in is 2-flop synchronised; only a rising edge starts capture, and only the first frame of a run waits for it.
- When undefined: no trig_in port, no WAIT_TRIG state; start enters CAPTURE directly.

Verification
REQ-034 FRAME_LEN=8, nframes=2, skip=0, continuous=0, tvalid_s and tready_m high -> 16 output beats, tuser on beats 0 and 8, tlast on 7 and 15, done one cycle after beat 15, frame_cnt=2.
REQ-035 FRAME_LEN=8, skip=3, nframes=2 -> input samples 8..10 discarded with tready_s=1; second frame carries samples 11..18.
REQ-036 Continuous run; cfg_abort pulsed at idx=3 -> frame completes through idx 7 with tlast, then IDLE and done; no further tvalid_m.
REQ-037 tready_m low for 5 cycles at idx=4 -> tready_s low, idx held at 4, output sequence contiguous with no gaps in the data values.
REQ-038 TRIG_EN build: start, trig_in low for 20 cycles -> busy=1, tvalid_m=0; trig_in rising -> first tuser 3 cycles later (sync + transition).
REQ-039 reset_n asserted at idx=5 and released, then start -> first output beat has tuser=1, frame_cnt restarts from 0.
